adder_result_capture: RTL and testbench
=======================================

Name: adder_result_capture

Overview:
- Sequential wrapper stage around the 16-bit ripple-carry adder built from gate-delayed full adders.
- Accepts operand pairs on a valid/ready handshake and drives them onto the adder's a/b inputs.
- Holds the operands stable for a programmable settle window while carries ripple, then latches s/c_out.
- Adds a signed-overflow flag and presents the result downstream on a valid/ready handshake. Also keeps a saturating count of completed additions.

Parameters:
- WIDTH, 16, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 4, clock cycles operands are held before sum is sampled. Must be >=1; elaboration error otherwise.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept operands
- in_a  input  WIDTH  operand A (two's complement)
- in_b  input  WIDTH  operand B (two's complement)
- add_a  output  WIDTH  registered operand A to adder
- add_b  output  WIDTH  registered operand B to adder
- add_s  input  WIDTH  adder sum
- add_cout  input  1  adder carry out
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  captured sum
- out_cout  output  1  captured carry out
- out_ovf  output  1  signed overflow of captured result
- busy  output  1  high in SETTLE or HOLD
- done_count  output  CNT_W  completed (handed-off) results, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset sampled on rising clk edge).
- Reset values: state=IDLE, add_a=0, add_b=0, out_sum=0, out_cout=0, out_ovf=0, out_valid=0, done_count=0, settle counter=0. in_ready=1 and busy=0 follow from IDLE.
- in_ready = (state==IDLE) and combinational from state only; it never depends on in_valid. busy = (state!=IDLE).
- IDLE:
  - On an edge with in_valid=1, load add_a<=in_a, add_b<=in_b and cnt<=SETTLE_CYCLES-1, and go to SETTLE.
  - in_a/in_b are ignored otherwise.
- SETTLE:
  - add_a/add_b are held constant.
  - If cnt!=0, cnt<=cnt-1.
  - If cnt==0, capture out_sum<=add_s and out_cout<=add_cout.
  - On that same capture edge, set out_ovf<=(add_a[W-1]==add_b[W-1]) && (add_s[W-1]!=add_a[W-1]), set out_valid<=1, and go to HOLD.
- HOLD:
  - out_* are stable while out_ready=0, indefinitely.
  - On an edge with out_ready=1: out_valid<=0, state<=IDLE, done_count<=done_count+1, saturating at all-ones.
  - add_a/add_b keep their last value until the next accept.
- Latency: if operands are accepted at edge T0, the capture happens at edge T0+SETTLE_CYCLES and out_valid is high from then on. Operands are held for exactly SETTLE_CYCLES full cycles before sampling.
- Throughput: one result per SETTLE_CYCLES+2 cycles minimum. in_ready stays 0 during the HOLD handoff edge, so a new accept is possible only on the edge after return to IDLE.
- out_sum/out_cout/out_ovf keep the last captured values after handoff until the next capture.
- Arithmetic: the block never computes the sum itself. out_sum/out_cout come from the adder; only out_ovf is derived locally from sign bits.
- Reset mid-operation, in SETTLE or HOLD: the transaction is discarded, all reset values apply on that edge, and no out_valid pulse occurs.
- in_valid asserted while busy has no effect and is not queued.

Test Plan:
- Reset with in_valid=1 held -> reset values on all outputs; in_ready=1; no accept during reset cycles.
- in_a=0xFFF6 (-10), in_b=0x0064 (100), SETTLE_CYCLES=4, out_ready=1 -> out_valid rises exactly 4 edges after accept. out_sum=0x005A, out_cout=1, out_ovf=0, and done_count increments to 1.
- in_a=0x7FFF, in_b=0x0001 -> out_sum=0x8000, cout=0, ovf=1. Then 0x8000+0x8000 -> out_sum=0x0000, cout=1, ovf=1.
- in_a=0xFFC5 (-59), in_b=0xFFF0 (-16), with out_ready=0 for 10 cycles -> out_sum=0xFFB5, cout=1, ovf=0, all stable for 10 cycles. in_ready=0 and a new in_valid (1000/2001) is ignored throughout. After out_ready=1, accept 1000+2001 -> out_sum=0x0BB9.
- Reset asserted 2 cycles into SETTLE -> next cycle all outputs are at reset values and no result is emitted. A subsequent 63+127 yields out_sum=0x00BE, cout=0, ovf=0.
- Run 260 back-to-back transactions with CNT_W=8 -> done_count saturates at 0xFF. Throughput is one result per SETTLE_CYCLES+2 cycles.

Source files
------------

// File: rtl/adder_result_capture_if.sv
// Handshake and adder-side signals of the adder result capture stage.
// The slave modport is the capture stage. The master modport is whatever
// drives operands, supplies the adder outputs and consumes results.
interface adder_result_capture_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  modport slave (
    input  in_valid, in_a, in_b, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf,
           busy, done_count
  );

  modport master (
    output in_valid, in_a, in_b, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf,
           busy, done_count
  );
endinterface

// File: rtl/adder_result_capture.sv
// Sequential wrapper around a gate-delayed ripple-carry adder. It registers
// an operand pair and holds it for SETTLE_CYCLES clocks while carries
// ripple. It then captures the adder's sum and carry, adds a signed-overflow
// flag and hands the result downstream. It also counts completed hand-offs,
// saturating at all-ones.
module adder_result_capture #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  adder_result_capture_if.slave bus
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_result_capture: SETTLE_CYCLES must be >= 1");
  end

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] done_q, done_d;

  // Next-state and datapath decode for the accept / settle / hold sequence.
  always_comb begin
    // NOTE: every _d starts as a copy of its _q, so no path through the case
    // leaves a signal unassigned and no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          add_a_d = bus.in_a;
          add_b_d = bus.in_b;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // The operands have been stable for SETTLE_CYCLES full cycles,
          // so the ripple has finished and the adder outputs are valid.
          out_sum_d   = bus.add_s;
          out_cout_d  = bus.add_cout;
          out_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                        (bus.add_s[WIDTH-1] != add_a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (done_q != {CNT_W{1'b1}}) begin
            done_d = done_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with a synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the reset is sampled on the clock edge like any other input. A
    // reset in SETTLE or HOLD drops the transaction without an out_valid pulse.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register take its _d value
      // from the same pre-edge snapshot, whatever order the lines are in.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.done_count = done_q;

endmodule

// File: tb/tb_adder_result_capture.sv
// Self-checking bench for adder_result_capture. A behavioural ripple adder
// drives ~sum until its operands have been stable long enough, so an early
// capture shows up as a wrong sum. Fixed vectors come from a table. Random
// back-to-back traffic is checked against an integer-arithmetic model.
module tb_adder_result_capture;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_done = 0;
  int   acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_result_capture_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  adder_result_capture #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Slow adder: the sum is correct only after the operands have been stable
  // for S-1 falling edges. Before that it drives the complement of the sum.
  logic [W-1:0] prev_a = '0, prev_b = '0;
  int           held   = 100;
  logic [W:0]   true_sum;
  always @(negedge clk) begin
    if (bus.add_a !== prev_a || bus.add_b !== prev_b) begin
      prev_a <= bus.add_a;
      prev_b <= bus.add_b;
      held   <= 0;
    end else if (held < 100) begin
      held <= held + 1;
    end
  end
  assign true_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign {bus.add_cout, bus.add_s} = (held >= S - 1) ? true_sum : ~true_sum;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: unsigned sum for s/cout, signed sum range for overflow.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c, output logic o);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int u  = ua + ub;
    int r  = sa + sb;
    s = u[W-1:0];
    c = (u > 65535);
    o = (r > 32767) || (r < -32768);
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_valid);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_in_ready", bus.in_ready, 1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    if (!keep_valid) bus.in_valid = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_in_ready_low", bus.in_ready, 0);
    check("accept_add_a", bus.add_a, a);
    check("accept_add_b", bus.add_b, b);
  endtask

  task automatic wait_result(input logic [W-1:0] s, input logic c, input logic o);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < S + 6);
    check("latency", n, S);
    check("out_valid", bus.out_valid, 1);
    check("out_sum", bus.out_sum, s);
    check("out_cout", bus.out_cout, c);
    check("out_ovf", bus.out_ovf, o);
  endtask

  // Caller has out_ready=1. One edge completes the hand-off.
  task automatic handoff(input logic [W-1:0] s);
    tick();
    if (exp_done < 255) exp_done++;
    check("handoff_out_valid", bus.out_valid, 0);
    check("handoff_in_ready", bus.in_ready, 1);
    check("handoff_busy", bus.busy, 0);
    check("handoff_sum_kept", bus.out_sum, s);
    check("done_count", bus.done_count, exp_done);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_add_a"}, bus.add_a, 0);
    check({tag, "_add_b"}, bus.add_b, 0);
    check({tag, "_out_sum"}, bus.out_sum, 0);
    check({tag, "_out_cout"}, bus.out_cout, 0);
    check({tag, "_out_ovf"}, bus.out_ovf, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_done_count"}, bus.done_count, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, s;
    logic         c, o;
    int           prev_acc;
    bit           saw_valid;

    vecs[0] = '{16'hFFF6, 16'h0064, 16'h005A, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'hFFC5, 16'hFFF0, 16'hFFB5, 1'b1, 1'b0};
    vecs[4] = '{16'h03E8, 16'h07D1, 16'h0BB9, 1'b0, 1'b0};
    vecs[5] = '{16'h003F, 16'h007F, 16'h00BE, 1'b0, 1'b0};

    // Reset with in_valid held high: nothing may be accepted.
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'h1234;
    bus.in_b      = 16'h4321;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("post_reset_idle", bus.busy, 0);

    // Table vectors 0..2 with downstream always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(vecs[i].a, vecs[i].b, 1'b0);
      wait_result(vecs[i].s, vecs[i].c, vecs[i].o);
      handoff(vecs[i].s);
    end

    // Downstream stalls for 10 cycles while new operands are offered.
    bus.out_ready = 1'b0;
    accept(vecs[3].a, vecs[3].b, 1'b0);
    wait_result(vecs[3].s, vecs[3].c, vecs[3].o);
    bus.in_a     = vecs[4].a;
    bus.in_b     = vecs[4].b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_sum", bus.out_sum, vecs[3].s);
      check("stall_out_cout", bus.out_cout, vecs[3].c);
      check("stall_out_ovf", bus.out_ovf, vecs[3].o);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_add_a", bus.add_a, vecs[3].a);
    end
    bus.out_ready = 1'b1;
    handoff(vecs[3].s);
    accept(vecs[4].a, vecs[4].b, 1'b0);
    wait_result(vecs[4].s, vecs[4].c, vecs[4].o);
    handoff(vecs[4].s);

    // Reset two cycles into SETTLE: transaction dropped, no out_valid.
    accept(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_done = 0;
    check_reset_values("mid_reset");
    saw_valid = 1'b0;
    for (int k = 0; k < S + 3; k++) begin
      tick();
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("mid_reset_no_result", saw_valid, 0);
    accept(vecs[5].a, vecs[5].b, 1'b0);
    wait_result(vecs[5].s, vecs[5].c, vecs[5].o);
    handoff(vecs[5].s);

    // 260 back-to-back random transactions with in_valid held high.
    prev_acc = 0;
    for (int i = 0; i < 260; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      ref_add(a, b, s, c, o);
      accept(a, b, 1'b1);
      if (i > 0) check("throughput", acc_cyc - prev_acc, S + 2);
      prev_acc = acc_cyc;
      wait_result(s, c, o);
      handoff(s);
    end
    bus.in_valid = 1'b0;
    check("done_saturated", bus.done_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
